reg_bank: RTL and testbench
===========================

Name: reg_bank

Overview:
Parametrised multi-entry register file that generalises the single 32-bit load register to DEPTH entries of WIDTH bits. It has one synchronous write port and two combinational read ports with write-to-read bypass. An optional hardwired zero entry and a per-entry busy scoreboard let the datapath stall on pending multi-cycle writes. It sits between the decode stage and the ALU/memory writeback of the processor datapath.

Parameters:
WIDTH, 32, data width of each entry (>=1)
DEPTH, 32, number of entries (>=2; non-power-of-2 allowed)
ZERO_REG, 1, 1 = entry 0 reads as 0, ignores writes, never busy; 0 = entry 0 is ordinary
AW (localparam), clog2(DEPTH), address width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write enable
wr_addr  in  AW  write address
wr_data  in  WIDTH  write data
rd_addr_a  in  AW  read port A address
rd_addr_b  in  AW  read port B address
rd_data_a  out  WIDTH  read port A data (combinational)
rd_data_b  out  WIDTH  read port B data (combinational)
busy_set  in  1  mark busy_addr as having a pending write
busy_addr  in  AW  entry to mark busy
busy_a  out  1  entry at rd_addr_a has a pending write
busy_b  out  1  entry at rd_addr_b has a pending write

Behaviour:
- Reset (clk edge with reset=1): all entries <= 0, all busy bits <= 0. reset overrides wr_en and busy_set in the same cycle.
- Write: on clk edge with wr_en=1 and a valid address, entry[wr_addr] <= wr_data. Without a write, entries hold their value.
- Invalid address: any address >= DEPTH. Writes to it are ignored, reads return 0, busy reads 0, busy_set on it is ignored.
- Read: rd_data_x = entry[rd_addr_x], with zero cycle latency.
- Bypass: if wr_en=1, wr_addr==rd_addr_x, and the address is valid and writable, then rd_data_x = wr_data in the same cycle (write-first). Ports A and B bypass independently; both may hit the same address.
- ZERO_REG=1: wr_en to address 0 is a no-op, and no bypass applies to it. rd_data_x is 0 when rd_addr_x==0. busy_set to 0 is ignored.
- Scoreboard:
  - busy[busy_addr] <= 1 on an edge with busy_set=1.
  - busy[wr_addr] <= 0 on an edge with wr_en=1 (valid, writable address).
  - Same address with busy_set and wr_en on the same edge: the set wins and the bit ends at 1 (new producer issued).
  - Different addresses on the same edge: both updates apply.
- busy_x = busy[rd_addr_x] & ~(wr_en & wr_addr==rd_addr_x). A write in flight this cycle is consumable through the bypass.
- Reset mid-operation clears pending busy bits. Any outstanding producer's later write just stores normally.
- No internal FSM beyond the storage and scoreboard arrays. All outputs are combinational from state plus the current inputs.

Decomposition:
- Shared package (cpu_pkg): default WIDTH/DEPTH constants, a function clog2, and the reg_addr_t width constant used by decode and writeback.
- One natural sub-module: reg_bank_scoreboard. It holds the DEPTH busy bits with set/clear/priority logic and two busy lookups with the bypass mask.
- Storage, write decode and read/bypass muxing stay in reg_bank.

Test Plan:
- Reset: write 0xDEADBEEF to entries 1..31, assert reset for 1 cycle. All reads return 0x00000000, busy_a/busy_b = 0.
- Write/read: write 0x12345678 to entry 5, then read A=5, B=5 next cycle. Both ports return 0x12345678; entry 6 still reads 0.
- Bypass: entry 7 holds 0x1; same cycle wr_en=1, wr_addr=7, wr_data=0xAAAA5555, rd_addr_a=7. rd_data_a = 0xAAAA5555 combinationally, and 0xAAAA5555 after the edge.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to 0, busy_set addr 0. rd_data_a(0)=0, busy_a=0. With ZERO_REG=0, the same sequence reads 0xFFFFFFFF.
- Scoreboard:
  - busy_set addr 9 → busy_a(9)=1 next cycle.
  - wr_en to 9 → busy_a=0 in that cycle (bypass) and after.
  - Simultaneous busy_set 9 and wr_en 9 → busy_a=1 after the edge, data updated.
- Reset vs write: reset=1 with wr_en=1, wr_addr=3, wr_data=0x55 → entry 3 reads 0.
- Non-power-of-2 (DEPTH=20): write 0x77 to addr 25 → no entry changes, and reading addr 25 returns 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath package.
// Holds the default register-file geometry, a constant-evaluable clog2,
// the register address type used by decode and writeback, and small
// address-qualification helpers shared by the register bank and its
// scoreboard.
package cpu_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    // Smallest n with 2**n >= value. Values of 0 or 1 return 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    localparam int REG_ADDR_W = clog2(DEFAULT_DEPTH);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Address maps to a real entry. Non-power-of-2 depths leave a hole
    // at the top of the address space.
    function automatic bit addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

    // Address is a real entry that may be written or marked busy.
    // A hardwired zero entry is excluded.
    function automatic bit addr_writable(input int unsigned addr, input int unsigned depth,
                                         input bit zero_reg);
        return (addr < depth) && !(zero_reg && addr == 0);
    endfunction

endpackage

// File: rtl/reg_bank_scoreboard.sv
// Per-entry busy scoreboard for reg_bank.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   clear_en, clear_addr  qualified write this cycle; clears the busy bit
//   busy_set, busy_addr   marks an entry as having a pending producer
//   rd_addr_a/b           lookup addresses
//   busy_a/b              busy bit of the looked-up entry, masked when the
//                         entry is being written this very cycle
module reg_bank_scoreboard
    import cpu_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_en,
    input  logic [AW-1:0] clear_addr,
    input  logic          busy_set,
    input  logic [AW-1:0] busy_addr,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic          busy_a,
    output logic          busy_b
);

    logic [DEPTH-1:0] busy;
    logic             set_ok;

    assign set_ok = busy_set && addr_writable(32'(busy_addr), DEPTH, ZERO_REG);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            // NOTE: non-blocking assignments to the same bit resolve to the
            // last one written, so placing the set after the clear makes a
            // newly issued producer win over the retiring write.
            if (clear_en) begin
                busy[clear_addr] <= 1'b0;
            end
            if (set_ok) begin
                busy[busy_addr] <= 1'b1;
            end
        end
    end

    // A write landing this cycle is visible through the data bypass, so the
    // consumer need not stall on it.
    assign busy_a = addr_in_range(32'(rd_addr_a), DEPTH) && busy[rd_addr_a]
                    && !(clear_en && clear_addr == rd_addr_a);
    assign busy_b = addr_in_range(32'(rd_addr_b), DEPTH) && busy[rd_addr_b]
                    && !(clear_en && clear_addr == rd_addr_b);

endmodule

// File: rtl/reg_bank.sv
// Parametrised register file: one synchronous write port, two
// combinational read ports with write-first bypass, optional hardwired
// zero entry and a per-entry busy scoreboard.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   wr_en, wr_addr, wr_data write port
//   rd_addr_a/b, rd_data_a/b combinational read ports
//   busy_set, busy_addr     mark an entry as awaiting a multi-cycle write
//   busy_a/b                pending-write flag for each read address
module reg_bank
    import cpu_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             busy_set,
    input  logic [AW-1:0]    busy_addr,
    output logic             busy_a,
    output logic             busy_b
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic [AW-1:0]    rd_addr [2];
    logic [WIDTH-1:0] rd_data [2];

    // Write qualified by a real, non-hardwired address; drives storage,
    // bypass and the scoreboard clear alike.
    assign wr_ok = wr_en && addr_writable(32'(wr_addr), DEPTH, ZERO_REG);

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the storage array is cleared on reset because software
            // relies on every entry reading zero afterwards; a bank that
            // only needs valid data after a write could skip this.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            // NOTE: default assignment first so every path drives the
            // output and no latch is inferred.
            rd_data[p] = '0;
            if (addr_writable(32'(rd_addr[p]), DEPTH, ZERO_REG)) begin
                if (wr_ok && wr_addr == rd_addr[p]) begin
                    rd_data[p] = wr_data;
                end else begin
                    rd_data[p] = mem[rd_addr[p]];
                end
            end
        end
    end

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];

    reg_bank_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .clear_en   (wr_ok),
        .clear_addr (wr_addr),
        .busy_set   (busy_set),
        .busy_addr  (busy_addr),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .busy_a     (busy_a),
        .busy_b     (busy_b)
    );

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank. Three instances share one stimulus stream:
//   inst 0: DEPTH=32, ZERO_REG=1
//   inst 1: DEPTH=32, ZERO_REG=0
//   inst 2: DEPTH=20, ZERO_REG=1
// The driver pushes expected outputs into a queue; a monitor on the
// falling edge pops and compares them against all instances.
module tb_reg_bank;

    localparam int NI = 3;
    localparam int DEPTHS [NI] = '{32, 32, 20};
    localparam bit ZREGS  [NI] = '{1'b1, 1'b0, 1'b1};

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        busy_set;
    logic [4:0]  busy_addr;

    logic [31:0] rd_data_a [NI];
    logic [31:0] rd_data_b [NI];
    logic        busy_a    [NI];
    logic        busy_b    [NI];

    reg_bank #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a[0]), .rd_data_b(rd_data_b[0]),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .busy_a(busy_a[0]), .busy_b(busy_b[0])
    );

    reg_bank #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a[1]), .rd_data_b(rd_data_b[1]),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .busy_a(busy_a[1]), .busy_b(busy_b[1])
    );

    reg_bank #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a[2]), .rd_data_b(rd_data_b[2]),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .busy_a(busy_a[2]), .busy_b(busy_b[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural contents and pending flags, indexed by
    // the full 5-bit address space; entries a configuration lacks are never
    // written and so always read zero.
    logic [31:0] model_mem  [NI][32];
    bit          model_busy [NI][32];

    typedef struct {
        int          cycle;
        logic [31:0] rda [NI];
        logic [31:0] rdb [NI];
        logic        ba  [NI];
        logic        bb  [NI];
    } exp_t;

    exp_t exp_q [$];

    int n_checks = 0;
    int n_fails  = 0;
    int cycle_no = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic bit accepted(input int i, input bit en, input int addr);
        return en && addr < DEPTHS[i] && !(ZREGS[i] && addr == 0);
    endfunction

    // Write-first: a read of the address being written sees the new value.
    function automatic logic [31:0] exp_read(input int i, input bit en, input int waddr,
                                             input logic [31:0] wdata, input int raddr);
        if (accepted(i, en, waddr) && raddr == waddr) return wdata;
        return model_mem[i][raddr];
    endfunction

    function automatic logic exp_busy(input int i, input bit en, input int waddr, input int raddr);
        if (accepted(i, en, waddr) && raddr == waddr) return 1'b0;
        return model_busy[i][raddr];
    endfunction

    // One clock cycle of stimulus. Outputs are checked on every non-reset
    // cycle; the model advances at the rising edge.
    task automatic cycle(input bit rst, input bit en, input int waddr, input logic [31:0] wdata,
                         input int ra, input int rb, input bit bset, input int baddr);
        exp_t e;
        reset     = rst;
        wr_en     = en;
        wr_addr   = 5'(waddr);
        wr_data   = wdata;
        rd_addr_a = 5'(ra);
        rd_addr_b = 5'(rb);
        busy_set  = bset;
        busy_addr = 5'(baddr);
        if (!rst) begin
            e.cycle = cycle_no;
            for (int i = 0; i < NI; i++) begin
                e.rda[i] = exp_read(i, en, waddr, wdata, ra);
                e.rdb[i] = exp_read(i, en, waddr, wdata, rb);
                e.ba[i]  = exp_busy(i, en, waddr, ra);
                e.bb[i]  = exp_busy(i, en, waddr, rb);
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                for (int a = 0; a < 32; a++) begin
                    model_mem[i][a]  = '0;
                    model_busy[i][a] = 1'b0;
                end
            end else begin
                if (accepted(i, en, waddr)) begin
                    model_mem[i][waddr]  = wdata;
                    model_busy[i][waddr] = 1'b0;
                end
                // The set is applied last so it wins on a shared address.
                if (accepted(i, bset, baddr)) model_busy[i][baddr] = 1'b1;
            end
        end
        cycle_no++;
        #1;
    endtask

    task automatic idle_read(input int ra, input int rb);
        cycle(1'b0, 1'b0, 0, 32'h0, ra, rb, 1'b0, 0);
    endtask

    // Monitor: compare whatever the driver has queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < NI; i++) begin
                    check($sformatf("c%0d i%0d rd_data_a", e.cycle, i), rd_data_a[i], e.rda[i]);
                    check($sformatf("c%0d i%0d rd_data_b", e.cycle, i), rd_data_b[i], e.rdb[i]);
                    check($sformatf("c%0d i%0d busy_a", e.cycle, i), 32'(busy_a[i]), 32'(e.ba[i]));
                    check($sformatf("c%0d i%0d busy_b", e.cycle, i), 32'(busy_b[i]), 32'(e.bb[i]));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < 32; a++) begin
                model_mem[i][a]  = '0;
                model_busy[i][a] = 1'b0;
            end
        end
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; busy_set = 1'b0; busy_addr = '0;
        #1;

        // Initial reset, then reset-state reads.
        cycle(1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b0, 0);
        cycle(1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b0, 0);
        idle_read(1, 31);

        // Fill 1..31 and mark each busy; then reset clears both.
        for (int a = 1; a < 32; a++) cycle(1'b0, 1'b1, a, 32'hDEADBEEF, a, a - 1, 1'b1, a);
        idle_read(13, 30);
        cycle(1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b0, 0);
        for (int a = 0; a < 32; a++) idle_read(a, 31 - a);

        // Write then read on both ports; neighbour untouched.
        cycle(1'b0, 1'b1, 5, 32'h12345678, 6, 6, 1'b0, 0);
        idle_read(5, 5);
        idle_read(6, 5);

        // Bypass over an existing value, then the stored value.
        cycle(1'b0, 1'b1, 7, 32'h00000001, 0, 0, 1'b0, 0);
        cycle(1'b0, 1'b1, 7, 32'hAAAA5555, 7, 7, 1'b0, 0);
        idle_read(7, 6);

        // Zero entry: write and busy_set to address 0.
        cycle(1'b0, 1'b1, 0, 32'hFFFFFFFF, 0, 1, 1'b1, 0);
        idle_read(0, 0);

        // Scoreboard set, clear with bypass, and set-wins on collision.
        cycle(1'b0, 1'b0, 0, 32'h0, 9, 8, 1'b1, 9);
        idle_read(9, 9);
        cycle(1'b0, 1'b1, 9, 32'h00000099, 9, 10, 1'b0, 0);
        idle_read(9, 9);
        cycle(1'b0, 1'b1, 9, 32'h0000ABCD, 9, 9, 1'b1, 9);
        idle_read(9, 9);

        // Reset overrides a same-cycle write.
        cycle(1'b1, 1'b1, 3, 32'h00000055, 3, 3, 1'b1, 3);
        idle_read(3, 9);

        // Address 25 is invalid only for the 20-entry instance.
        cycle(1'b0, 1'b1, 25, 32'h00000077, 25, 19, 1'b1, 25);
        idle_read(25, 19);

        // Random traffic, biased toward bypass and scoreboard collisions.
        for (int n = 0; n < 600; n++) begin
            int waddr, ra, rb, baddr;
            bit en, bset, rst;
            waddr = $urandom_range(0, 31);
            en    = ($urandom_range(0, 1) == 1);
            bset  = ($urandom_range(0, 2) == 0);
            baddr = ($urandom_range(0, 3) == 0) ? waddr : $urandom_range(0, 31);
            ra    = ($urandom_range(0, 1) == 1) ? waddr : $urandom_range(0, 31);
            rb    = ($urandom_range(0, 2) == 0) ? baddr : $urandom_range(0, 31);
            rst   = ($urandom_range(0, 49) == 0);
            cycle(rst, en, waddr, $urandom, ra, rb, bset, baddr);
        end

        idle_read(0, 1);
        repeat (2) @(posedge clk);
        check("expect_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
